// File: rtl/user_ascon_pkg.sv
// Register map, bus/state types and small helpers shared by the user-domain
// ASCON permutation slot.
package user_ascon_pkg;

   localparam int unsigned AidWidth = 4;

   typedef struct packed {
      logic                req;
      logic [31:0]         addr;
      logic                we;
      logic [3:0]          be;
      logic [31:0]         wdata;
      logic [AidWidth-1:0] aid;
   } ascon_obi_req_t;

   typedef struct packed {
      logic                gnt;
      logic                rvalid;
      logic [31:0]         rdata;
      logic [AidWidth-1:0] rid;
      logic                err;
   } ascon_obi_rsp_t;

   // Lane k is x_k; lane 0 sits in the low 64 bits.
   typedef logic [4:0][63:0] ascon_state_t;

   typedef enum logic {Idle, Run} fsm_e;

   localparam logic [9:0] OffCtrl   = 10'h000;
   localparam logic [9:0] OffStatus = 10'h001;
   localparam logic [9:0] OffState0 = 10'h002;
   localparam logic [9:0] OffState9 = 10'h00B;

   localparam int unsigned CtrlStartBit  = 0;
   localparam int unsigned CtrlRoundsLsb = 4;
   localparam int unsigned CtrlIrqEnBit  = 8;
   localparam int unsigned StatusDoneBit = 1;
   localparam int unsigned StatusErrBit  = 2;

   localparam logic [3:0] MaxRounds = 4'd12;
   localparam logic [3:0] LastRound = 4'd11;

   function automatic logic [7:0] round_const(input logic [3:0] i);
      return {4'hF - i, i};
   endfunction

   function automatic logic [3:0] legal_rounds(input logic [3:0] r);
      return (r == 4'd0 || r > MaxRounds) ? MaxRounds : r;
   endfunction

   function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
      return (x >> n) | (x << (64 - n));
   endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, 5-bit S-box layer and
// per-lane linear diffusion.
module ascon_round
   import user_ascon_pkg::*;
(
   input  ascon_state_t state_i,
   input  logic [7:0]   rc_i,
   output ascon_state_t state_o
);

   localparam int unsigned RotA [5] = '{19, 61, 1, 10, 7};
   localparam int unsigned RotB [5] = '{28, 39, 6, 17, 41};

   ascon_state_t a;
   ascon_state_t b;
   ascon_state_t c;

   assign a[0] = state_i[0] ^ state_i[4];
   assign a[1] = state_i[1];
   assign a[2] = state_i[2] ^ {56'd0, rc_i} ^ state_i[1];
   assign a[3] = state_i[3];
   assign a[4] = state_i[4] ^ state_i[3];

   // Chi-like core of the S-box, bit-sliced across all 64 columns.
   for (genvar gi = 0; gi < 5; gi++) begin : g_chi
      assign b[gi] = a[gi] ^ (~a[(gi + 1) % 5] & a[(gi + 2) % 5]);
   end

   assign c[0] = b[0] ^ b[4];
   assign c[1] = b[1] ^ b[0];
   assign c[2] = ~b[2];
   assign c[3] = b[3] ^ b[2];
   assign c[4] = b[4];

   for (genvar gi = 0; gi < 5; gi++) begin : g_linear
      assign state_o[gi] = c[gi] ^ ror64(c[gi], RotA[gi]) ^ ror64(c[gi], RotB[gi]);
   end

endmodule

// File: rtl/user_ascon_ctrl.sv
// OBI register file around the ASCON state plus the round sequencer that runs
// p^a one round per cycle after a software START.
module user_ascon_ctrl
   import user_ascon_pkg::*;
#(
   parameter type         obi_req_t     = ascon_obi_req_t,
   parameter type         obi_rsp_t     = ascon_obi_rsp_t,
   parameter int unsigned DefaultRounds = 12
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  obi_req_t obi_req_i,
   output obi_rsp_t obi_rsp_o,
   output logic     irq_o
);

   localparam logic [3:0] ResetRounds = legal_rounds(4'(DefaultRounds));

   ascon_state_t        state_reg, state_next, round_out;
   logic [3:0]          rounds_reg, rounds_next;
   logic [3:0]          idx_reg, idx_next;
   logic                irq_en_reg, irq_en_next;
   logic                done_reg, done_next;
   logic                err_reg, err_next;
   logic                irq_reg;
   fsm_e                fsm_reg, fsm_next;
   logic                rvalid_reg;
   logic [31:0]         rdata_reg, rdata_next;
   logic [AidWidth-1:0] rid_reg;
   logic                rsp_err_reg, rsp_err_next;

   logic [9:0]  word_off;
   logic        is_ctrl, is_status, is_state, mapped, busy, wr, start_bit;
   logic [3:0]  state_word, new_rounds;
   logic [2:0]  lane;
   logic        half;
   logic [31:0] wdata, read_word;
   logic [3:0]  be;
   logic [7:0]  rc;
   logic        unused_addr_bits;

   assign word_off         = obi_req_i.addr[11:2];
   assign unused_addr_bits = ^{obi_req_i.addr[31:12], obi_req_i.addr[1:0]};
   assign wdata            = obi_req_i.wdata;
   assign be               = obi_req_i.be;
   assign is_ctrl          = (word_off == OffCtrl);
   assign is_status        = (word_off == OffStatus);
   assign is_state         = (word_off >= OffState0) && (word_off <= OffState9);
   assign mapped           = is_ctrl | is_status | is_state;
   assign state_word       = 4'(word_off - OffState0);
   assign lane             = state_word[3:1];
   assign half             = state_word[0];
   assign new_rounds       = legal_rounds(wdata[CtrlRoundsLsb +: 4]);
   assign busy             = (fsm_reg == Run);
   assign wr               = obi_req_i.req & obi_req_i.we;
   assign start_bit        = be[0] & wdata[CtrlStartBit];
   assign rc               = round_const(idx_reg);

   ascon_round u_round (
      .state_i (state_reg),
      .rc_i    (rc),
      .state_o (round_out)
   );

   always_comb begin
      read_word = '0;
      if (is_ctrl) begin
         read_word = {23'd0, irq_en_reg, rounds_reg, 4'd0};
      end else if (is_status) begin
         read_word = {29'd0, err_reg, done_reg, busy};
      end else if (is_state) begin
         read_word = half ? state_reg[lane][63:32] : state_reg[lane][31:0];
      end
   end

   always_comb begin
      state_next   = state_reg;
      rounds_next  = rounds_reg;
      irq_en_next  = irq_en_reg;
      done_next    = done_reg;
      err_next     = err_reg;
      fsm_next     = fsm_reg;
      idx_next     = idx_reg;
      rdata_next   = '0;
      rsp_err_next = 1'b0;

      if (busy) begin
         state_next = round_out;
         idx_next   = idx_reg + 4'd1;
         if (idx_reg == LastRound) begin
            fsm_next = Idle;
         end
      end

      if (obi_req_i.req) begin
         if (!mapped) begin
            rsp_err_next = 1'b1;
         end else if (!obi_req_i.we) begin
            rdata_next = read_word;
         end else if (is_ctrl) begin
            if (be[0]) rounds_next = new_rounds;
            if (be[1]) irq_en_next = wdata[CtrlIrqEnBit];
            // Starting offsets the index so the last executed round is always i = 11.
            if (start_bit && !busy) begin
               fsm_next  = Run;
               idx_next  = MaxRounds - new_rounds;
               done_next = 1'b0;
            end
         end else if (is_status) begin
            if (be[0] && wdata[StatusDoneBit]) done_next = 1'b0;
            if (be[0] && wdata[StatusErrBit])  err_next  = 1'b0;
         end else if (busy) begin
            rsp_err_next = 1'b1;
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) state_next[lane][{half, 2'(b), 3'b000} +: 8] = wdata[8*b +: 8];
            end
         end
      end

      // Status sets are applied last so they win over a same-cycle W1C.
      if (busy && idx_reg == LastRound) done_next = 1'b1;
      if (wr && ((is_state && busy) || (is_ctrl && start_bit && busy))) err_next = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg   <= '0;
         rounds_reg  <= ResetRounds;
         irq_en_reg  <= 1'b0;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
         fsm_reg     <= Idle;
         idx_reg     <= 4'd0;
         irq_reg     <= 1'b0;
         rvalid_reg  <= 1'b0;
         rdata_reg   <= '0;
         rid_reg     <= '0;
         rsp_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         rounds_reg  <= rounds_next;
         irq_en_reg  <= irq_en_next;
         done_reg    <= done_next;
         err_reg     <= err_next;
         fsm_reg     <= fsm_next;
         idx_reg     <= idx_next;
         irq_reg     <= done_reg & irq_en_reg;
         rvalid_reg  <= obi_req_i.req;
         rdata_reg   <= rdata_next;
         rid_reg     <= obi_req_i.aid;
         rsp_err_reg <= rsp_err_next;
      end
   end

   always_comb begin
      obi_rsp_o        = '0;
      obi_rsp_o.gnt    = obi_req_i.req;
      obi_rsp_o.rvalid = rvalid_reg;
      obi_rsp_o.rdata  = rdata_reg;
      obi_rsp_o.rid    = rid_reg;
      obi_rsp_o.err    = rsp_err_reg;
   end

   assign irq_o = irq_reg;

endmodule

// File: tb/tb_user_ascon_ctrl.sv
// Scoreboard bench for user_ascon_ctrl: every request pushes its expected
// response, a negedge monitor pops and compares each rvalid.
module tb_user_ascon_ctrl;
   import user_ascon_pkg::*;

   typedef logic [4:0][63:0] st_t;
   typedef struct {
      logic [31:0] data;
      logic        err;
      logic [3:0]  id;
   } exp_t;

   localparam logic [11:0] A_CTRL   = 12'h000;
   localparam logic [11:0] A_STATUS = 12'h004;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   ascon_obi_req_t req = '0;
   ascon_obi_rsp_t rsp;
   logic           irq;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   logic prev_req = 1'b0;
   logic [3:0] next_id = 4'd0;

   logic [4:0] sbox [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                             5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                             5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                             5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   always #5 clk = ~clk;

   user_ascon_ctrl #(
      .obi_req_t     (ascon_obi_req_t),
      .obi_rsp_t     (ascon_obi_rsp_t),
      .DefaultRounds (12)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .obi_req_i (req),
      .obi_rsp_o (rsp),
      .irq_o     (irq)
   );

   // ---------------- golden model (table-driven S-box) ----------------
   function automatic logic [63:0] rr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic st_t model_perm(input st_t s_in, input int a);
      st_t s, t;
      logic [4:0] col, sb;
      int i;
      s = s_in;
      t = '0;
      for (int r = 0; r < a; r++) begin
         i = 12 - a + r;
         s[2] = s[2] ^ 64'(((15 - i) << 4) | i);
         for (int bi = 0; bi < 64; bi++) begin
            col = {s[0][bi], s[1][bi], s[2][bi], s[3][bi], s[4][bi]};
            sb  = sbox[col];
            t[0][bi] = sb[4]; t[1][bi] = sb[3]; t[2][bi] = sb[2];
            t[3][bi] = sb[1]; t[4][bi] = sb[0];
         end
         s[0] = t[0] ^ rr(t[0], 19) ^ rr(t[0], 28);
         s[1] = t[1] ^ rr(t[1], 61) ^ rr(t[1], 39);
         s[2] = t[2] ^ rr(t[2], 1)  ^ rr(t[2], 6);
         s[3] = t[3] ^ rr(t[3], 10) ^ rr(t[3], 17);
         s[4] = t[4] ^ rr(t[4], 7)  ^ rr(t[4], 41);
      end
      return s;
   endfunction

   function automatic logic [31:0] get_word(input st_t s, input int w);
      return w[0] ? s[w >> 1][63:32] : s[w >> 1][31:0];
   endfunction

   function automatic st_t rand_state();
      st_t s;
      for (int k = 0; k < 5; k++) s[k] = {$urandom(), $urandom()};
      return s;
   endfunction

   // ---------------- response monitor / scoreboard ----------------
   always @(negedge clk) begin
      exp_t e;
      if (rst_n !== 1'b1) begin
         prev_req = 1'b0;
      end else begin
         checks++;
         if (rsp.rvalid !== prev_req) begin
            errors++;
            $display("FAIL rvalid_timing: got %b want %b", rsp.rvalid, prev_req);
         end
         if (rsp.rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_rvalid: got rvalid=1 want no response");
            end else begin
               e = exp_q.pop_front();
               $display("rsp id=%0d rdata=%08h err=%0b", rsp.rid, rsp.rdata, rsp.err);
               checks++;
               if (rsp.err !== e.err) begin
                  errors++;
                  $display("FAIL rsp_err id=%0d: got %b want %b", e.id, rsp.err, e.err);
               end
               checks++;
               if (rsp.rid !== e.id) begin
                  errors++;
                  $display("FAIL rsp_rid: got %0d want %0d", rsp.rid, e.id);
               end
               checks++;
               if (rsp.rdata !== e.data) begin
                  errors++;
                  $display("FAIL rsp_rdata id=%0d: got %08h want %08h", e.id, rsp.rdata, e.data);
               end
            end
         end
         if (req.req === 1'b1) begin
            checks++;
            if (rsp.gnt !== 1'b1) begin
               errors++;
               $display("FAIL gnt: got %b want 1", rsp.gnt);
            end
         end
         prev_req = req.req;
      end
   end

   // ---------------- bus driver tasks ----------------
   task automatic drive(input logic [11:0] off, input logic we, input logic [3:0] be,
                        input logic [31:0] wdata, input logic [31:0] exp_data, input logic exp_err);
      exp_t e;
      req.req   = 1'b1;
      req.addr  = 32'h2000_0000 | {20'd0, off};
      req.we    = we;
      req.be    = be;
      req.wdata = wdata;
      req.aid   = next_id;
      e.data = exp_data;
      e.err  = exp_err;
      e.id   = next_id;
      exp_q.push_back(e);
      next_id = next_id + 4'd1;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      req.req = 1'b0;
      req.we  = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic rd(input logic [11:0] off, input logic [31:0] exp_data);
      drive(off, 1'b0, 4'hF, 32'd0, exp_data, 1'b0);
      idle(1);
   endtask

   task automatic wr(input logic [11:0] off, input logic [31:0] data);
      drive(off, 1'b1, 4'hF, data, 32'd0, 1'b0);
      idle(1);
   endtask

   task automatic write_state(input st_t s);
      for (int w = 0; w < 10; w++) wr(12'(8 + 4 * w), get_word(s, w));
   endtask

   task automatic read_state(input st_t s);
      for (int w = 0; w < 10; w++) rd(12'(8 + 4 * w), get_word(s, w));
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rsp.rvalid !== 1'b0 || rsp.gnt !== 1'b0 || rsp.err !== 1'b0) begin
         errors++;
         $display("FAIL reset_rsp: got rvalid=%b gnt=%b err=%b want 0 0 0", rsp.rvalid, rsp.gnt, rsp.err);
      end
      checks++;
      if (rsp.rdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_rdata: got %08h want 00000000", rsp.rdata);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq: got %b want 0", irq);
      end
      rst_n = 1'b1;
      idle(1);
      rd(A_CTRL, 32'h0000_00C0);
      rd(A_STATUS, 32'h0);
   endtask

   task automatic test_perm12();
      st_t z;
      z = '0;
      write_state(z);
      drive(A_CTRL, 1'b1, 4'hF, 32'h0000_01C1, 32'd0, 1'b0);
      for (int k = 1; k <= 13; k++) begin
         drive(A_STATUS, 1'b0, 4'hF, 32'd0, (k <= 12) ? 32'h1 : 32'h2, 1'b0);
         checks++;
         if (irq !== (k == 13)) begin
            errors++;
            $display("FAIL irq_p12 k=%0d: got %b want %b", k, irq, (k == 13));
         end
      end
      idle(1);
      read_state(model_perm(z, 12));
      rd(A_CTRL, 32'h0000_01C0);
      drive(A_STATUS, 1'b1, 4'hF, 32'h2, 32'd0, 1'b0);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_lag: got %b want 1", irq);
      end
      idle(1);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_clear: got %b want 0", irq);
      end
      rd(A_STATUS, 32'h0);
   endtask

   task automatic test_perm6();
      st_t s;
      s = rand_state();
      write_state(s);
      drive(A_CTRL, 1'b1, 4'hF, 32'h0000_0061, 32'd0, 1'b0);
      for (int k = 1; k <= 7; k++) begin
         drive(A_STATUS, 1'b0, 4'hF, 32'd0, (k <= 6) ? 32'h1 : 32'h2, 1'b0);
         checks++;
         if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_p6 k=%0d: got %b want 0", k, irq);
         end
      end
      idle(1);
      read_state(model_perm(s, 6));
      rd(A_CTRL, 32'h0000_0060);
      wr(A_STATUS, 32'h2);
   endtask

   task automatic test_busy_errors();
      st_t s;
      s = rand_state();
      write_state(s);
      drive(A_CTRL, 1'b1, 4'hF, 32'h0000_00C1, 32'd0, 1'b0);
      drive(12'h014, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'd0, 1'b1);
      drive(A_CTRL, 1'b1, 4'hF, 32'h0000_00C1, 32'd0, 1'b0);
      drive(A_STATUS, 1'b0, 4'hF, 32'd0, 32'h5, 1'b0);
      drive(A_STATUS, 1'b1, 4'hF, 32'h4, 32'd0, 1'b0);
      for (int k = 5; k <= 13; k++) begin
         drive(A_STATUS, 1'b0, 4'hF, 32'd0, (k <= 12) ? 32'h1 : 32'h2, 1'b0);
      end
      idle(1);
      read_state(model_perm(s, 12));
      wr(A_STATUS, 32'h2);
   endtask

   task automatic test_unmapped();
      drive(12'h030, 1'b0, 4'hF, 32'd0, 32'd0, 1'b1);
      drive(12'hFFC, 1'b0, 4'hF, 32'd0, 32'd0, 1'b1);
      drive(12'h030, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'd0, 1'b1);
      idle(1);
      rd(A_CTRL, 32'h0000_00C0);
      rd(A_STATUS, 32'h0);
   endtask

   task automatic test_back_to_back();
      wr(12'h00C, 32'h1122_3344);
      wr(12'h008, 32'hCAFE_F00D);
      drive(12'h008, 1'b0, 4'hF, 32'd0, 32'hCAFE_F00D, 1'b0);
      drive(12'h00C, 1'b1, 4'b0101, 32'hAABB_CCDD, 32'd0, 1'b0);
      drive(12'h00C, 1'b0, 4'hF, 32'd0, 32'h11BB_33DD, 1'b0);
      idle(1);
      drive(A_CTRL, 1'b1, 4'b0010, 32'h0000_0101, 32'd0, 1'b0);
      idle(1);
      rd(A_CTRL, 32'h0000_01C0);
      rd(A_STATUS, 32'h0);
      drive(A_CTRL, 1'b1, 4'b0001, 32'h0000_0030, 32'd0, 1'b0);
      idle(1);
      rd(A_CTRL, 32'h0000_0130);
      drive(A_CTRL, 1'b1, 4'b0001, 32'h0000_00F0, 32'd0, 1'b0);
      idle(1);
      rd(A_CTRL, 32'h0000_01C0);
      drive(A_CTRL, 1'b1, 4'b0011, 32'h0000_0000, 32'd0, 1'b0);
      idle(1);
      rd(A_CTRL, 32'h0000_00C0);
   endtask

   task automatic test_done_race();
      st_t s;
      s = rand_state();
      write_state(s);
      drive(A_CTRL, 1'b1, 4'hF, 32'h0000_0011, 32'd0, 1'b0);
      drive(A_STATUS, 1'b1, 4'hF, 32'h2, 32'd0, 1'b0);
      drive(A_STATUS, 1'b0, 4'hF, 32'd0, 32'h2, 1'b0);
      idle(1);
      read_state(model_perm(s, 1));
      wr(A_STATUS, 32'h2);
      rd(A_STATUS, 32'h0);
   endtask

   task automatic test_reset_midrun();
      st_t s, z;
      s = rand_state();
      z = '0;
      write_state(s);
      drive(A_CTRL, 1'b1, 4'hF, 32'h0000_01C1, 32'd0, 1'b0);
      idle(3);
      rst_n = 1'b0;
      idle(2);
      checks++;
      if (rsp.rvalid !== 1'b0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset_outputs: got rvalid=%b irq=%b want 0 0", rsp.rvalid, irq);
      end
      rst_n = 1'b1;
      idle(1);
      rd(A_STATUS, 32'h0);
      rd(A_CTRL, 32'h0000_00C0);
      read_state(z);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_perm12();
      test_perm6();
      test_busy_errors();
      test_unmapped();
      test_back_to_back();
      test_done_race();
      test_reset_midrun();
      idle(2);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_responses: got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
